// File: rtl/press_classifier_pkg.sv
// Shared types and default timing for the push-button gesture classifier.
// Constants only; no logic, so no latency.
// No flow control is involved.
package press_classifier_pkg;

   // FSM state encoding
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PRESS1 = 2'd1,
      GAP    = 2'd2,
      HOLD   = 2'd3
   } state_t;

   // Default tick counts for the 100 Hz sample clock
   localparam int LONG_TICKS_DEF   = 100;  // 1 s held -> long press
   localparam int DCLICK_TICKS_DEF = 30;   // 0.3 s low -> double-press window closes
   localparam int CNT_W_DEF        = 8;

endpackage

// File: rtl/press_classifier.sv
// Classifies debounced button gestures into short / double / long press pulses.
// Pulses appear one cycle after the deciding sample edge; busy decodes the state register.
// No backpressure: pulses are one-cycle events that downstream must sample when asserted.
module press_classifier
   import press_classifier_pkg::*;
#(
   parameter int LONG_TICKS   = LONG_TICKS_DEF,
   parameter int DCLICK_TICKS = DCLICK_TICKS_DEF,
   parameter int CNT_W        = CNT_W_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pb_debounced,
   output logic short_press,
   output logic double_press,
   output logic long_press,
   output logic busy
);

   localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
   localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_TICKS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             pb_q;
   logic             short_nxt, double_nxt, long_nxt;
   logic             rise;

   // A gesture only starts on a genuine 0->1 transition of the button level
   assign rise = pb_debounced && !pb_q;
   assign busy = (state != IDLE);

   // State, shared tick counter, edge register and registered event pulses.
   // pb_q resets high so a button held through reset cannot look like a fresh rise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         pb_q         <= 1'b1;
         short_press  <= 1'b0;
         double_press <= 1'b0;
         long_press   <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         pb_q         <= pb_debounced;
         short_press  <= short_nxt;
         double_press <= double_nxt;
         long_press   <= long_nxt;
      end
   end

   // Next-state, counter update and pulse decisions; pulses default low every cycle
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      short_nxt  = 1'b0;
      double_nxt = 1'b0;
      long_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (rise) begin
               state_nxt = PRESS1;
               cnt_nxt   = CNT_ONE;
            end
         end
         PRESS1: begin
            if (pb_debounced) begin
               if (cnt == LONG_LAST) begin
                  long_nxt  = 1'b1;
                  state_nxt = HOLD;
               end else begin
                  cnt_nxt = cnt + CNT_ONE;
               end
            end else begin
               state_nxt = GAP;
               cnt_nxt   = CNT_ONE;
            end
         end
         GAP: begin
            if (pb_debounced) begin
               double_nxt = 1'b1;
               state_nxt  = HOLD;
            end else if (cnt == DCLICK_LAST) begin
               short_nxt = 1'b1;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         HOLD: begin
            // Second presses and long holds both end here; only release matters
            if (!pb_debounced) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_press_classifier.sv
// Directed bench for press_classifier with LONG_TICKS=10, DCLICK_TICKS=5.
// Outputs are checked 1 time unit after each rising edge.
// Expected vectors are {short_press, double_press, long_press, busy}.
module tb_press_classifier;

   logic clk = 1'b0;
   logic rst_n;
   logic pb_debounced;
   logic short_press, double_press, long_press, busy;

   int tests = 0;
   int fails = 0;

   press_classifier #(
      .LONG_TICKS   (10),
      .DCLICK_TICKS (5),
      .CNT_W        (8)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pb_debounced (pb_debounced),
      .short_press  (short_press),
      .double_press (double_press),
      .long_press   (long_press),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] exp);
      logic [3:0] obs;
      obs = {short_press, double_press, long_press, busy};
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed {s,d,l,busy}=%b required %b", tag, obs, exp);
      end
   endtask

   // Drive one sample, clock it in, then check the registered outputs
   task automatic steps(input logic pb, input int n, input logic [3:0] exp, input string tag);
      for (int i = 0; i < n; i++) begin
         pb_debounced = pb;
         @(posedge clk);
         #1;
         chk(tag, exp);
      end
   endtask

   initial begin
      rst_n        = 1'b1;
      pb_debounced = 1'b1;
      #2 rst_n = 1'b0;
      #1 chk("reset_async", 4'b0000);
      repeat (3) @(posedge clk);
      #1 chk("reset_held", 4'b0000);
      rst_n = 1'b1;

      // Button held through reset must be ignored until released
      steps(1'b1, 20, 4'b0000, "held_thru_reset_hi");
      steps(1'b0, 10, 4'b0000, "held_thru_reset_lo");

      // Short press: 3 high, short_press after 5th low, busy falls with it
      steps(1'b1, 3, 4'b0001, "short_hi");
      steps(1'b0, 4, 4'b0001, "short_gap");
      steps(1'b0, 1, 4'b1000, "short_pulse");
      steps(1'b0, 2, 4'b0000, "short_after");

      // Double press: 3 high, 2 low, 3 high, low
      steps(1'b1, 3, 4'b0001, "dbl_hi1");
      steps(1'b0, 2, 4'b0001, "dbl_gap");
      steps(1'b1, 1, 4'b0101, "dbl_pulse");
      steps(1'b1, 2, 4'b0001, "dbl_hold");
      steps(1'b0, 1, 4'b0000, "dbl_release");
      steps(1'b0, 6, 4'b0000, "dbl_no_short");

      // Long press: 12 high then low
      steps(1'b1, 9, 4'b0001, "long_hi");
      steps(1'b1, 1, 4'b0011, "long_pulse");
      steps(1'b1, 2, 4'b0001, "long_hold");
      steps(1'b0, 1, 4'b0000, "long_release");
      steps(1'b0, 6, 4'b0000, "long_after");

      // Boundary: 9 high is not long; short after 5 lows
      steps(1'b1, 9, 4'b0001, "hi9");
      steps(1'b0, 4, 4'b0001, "hi9_gap");
      steps(1'b0, 1, 4'b1000, "hi9_short");
      steps(1'b0, 1, 4'b0000, "hi9_after");

      // Boundary: gap of 4 lows then high -> double
      steps(1'b1, 2, 4'b0001, "gap4_hi");
      steps(1'b0, 4, 4'b0001, "gap4_gap");
      steps(1'b1, 1, 4'b0101, "gap4_double");
      steps(1'b0, 1, 4'b0000, "gap4_release");
      steps(1'b0, 2, 4'b0000, "gap4_after");

      // Boundary: gap of 5 lows -> short, then a fresh gesture right after
      steps(1'b1, 2, 4'b0001, "gap5_hi");
      steps(1'b0, 4, 4'b0001, "gap5_gap");
      steps(1'b0, 1, 4'b1000, "gap5_short");
      steps(1'b1, 1, 4'b0001, "gap5_new_press");
      steps(1'b0, 4, 4'b0001, "gap5_new_gap");
      steps(1'b0, 1, 4'b1000, "gap5_new_short");
      steps(1'b0, 1, 4'b0000, "gap5_new_after");

      // Long second press produces no long_press
      steps(1'b1, 2, 4'b0001, "dlong_hi1");
      steps(1'b0, 1, 4'b0001, "dlong_gap");
      steps(1'b1, 1, 4'b0101, "dlong_double");
      steps(1'b1, 15, 4'b0001, "dlong_hold");
      steps(1'b0, 1, 4'b0000, "dlong_release");

      // Reset asserted mid-cycle while in GAP discards the gesture
      steps(1'b1, 3, 4'b0001, "mid_rst_hi");
      steps(1'b0, 2, 4'b0001, "mid_rst_gap");
      #2 rst_n = 1'b0;
      #1 chk("mid_rst_async", 4'b0000);
      @(posedge clk);
      #1 chk("mid_rst_held", 4'b0000);
      rst_n = 1'b1;
      steps(1'b0, 10, 4'b0000, "mid_rst_no_short");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
